// File: rtl/spi_pkg.sv
/*------------------------------------------------------------------------------
 * Module   : spi_pkg
 * Purpose  : Shared constants for the SPI slave endpoint (FSM encoding, widths).
 * Revision : 1.0 - initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

package spi_pkg;

  localparam int SPI_BITS = 8;

  localparam logic [7:0] IDLE_BYTE_DEF = 8'hFF;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage : spi_pkg

`default_nettype wire

// File: rtl/spi_sync_edge.sv
/*------------------------------------------------------------------------------
 * Module   : spi_sync_edge
 * Purpose  : N-stage input synchronizer with optional rise/fall detection.
 * Revision : 1.0 - initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter bit   EDGE_EN = 1'b1,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          prev_q <= RST_VAL;
        end else begin
          prev_q <= sync_q[STAGES-1];
        end
      end

      assign rise_o = sync_q[STAGES-1] & ~prev_q;
      assign fall_o = ~sync_q[STAGES-1] & prev_q;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule : spi_sync_edge

`default_nettype wire

// File: rtl/spi_slave.sv
/*------------------------------------------------------------------------------
 * Module   : spi_slave
 * Purpose  : SPI mode-0 MSB-first slave, oversampled into clk, with a
 *            one-entry transmit holding buffer. Optional macro
 *            SPI_SLAVE_UNDERRUN_EN adds the tx_underrun_o pulse output.
 * Revision : 1.0 - initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module spi_slave
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck_i,
  input  logic       cs_n_i,
  input  logic       mosi_i,
  output logic       miso_o,
  input  logic [7:0] tx_byte_i,
  input  logic       tx_byte_valid_i,
  output logic       ready_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_byte_valid_o,
  output logic       busy_o
`ifdef SPI_SLAVE_UNDERRUN_EN
  ,
  output logic       tx_underrun_o
`endif
);

  logic       sck_s, sck_rise, sck_fall;
  logic       cs_s, cs_rise, cs_fall;
  logic       mosi_s;
  logic [1:0] mosi_edge_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1), .RST_VAL(1'b0)) u_sync_sck (
    .clk    (clk),
    .rst    (rst),
    .d_i    (sck_i),
    .q_o    (sck_s),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1), .RST_VAL(1'b1)) u_sync_cs (
    .clk    (clk),
    .rst    (rst),
    .d_i    (cs_n_i),
    .q_o    (cs_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0), .RST_VAL(1'b0)) u_sync_mosi (
    .clk    (clk),
    .rst    (rst),
    .d_i    (mosi_i),
    .q_o    (mosi_s),
    .rise_o (mosi_edge_unused[0]),
    .fall_o (mosi_edge_unused[1])
  );

  logic [0:0]           state_q,    state_d;
  logic [7:0]           tx_shift_q, tx_shift_d;
  logic [7:0]           rx_shift_q, rx_shift_d;
  logic [3:0]           bit_cnt_q,  bit_cnt_d;
  logic                 reload_q,   reload_d;
  logic [7:0]           rx_byte_q,  rx_byte_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [7:0]           buf_q,      buf_d;
  logic                 buf_full_q, buf_full_d;
  logic                 armed_q,    armed_d;
  logic [SYNC_STAGES:0] flush_q,    flush_d;
  logic                 load;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic                 underrun_q, underrun_d;
`endif

  // A chip select already low when reset releases must not start a transfer:
  // the slave arms only after the flushed synchronizer has seen cs_n high.
  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    bit_cnt_d  = bit_cnt_q;
    reload_d   = reload_q;
    rx_byte_d  = rx_byte_q;
    rx_valid_d = 1'b0;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    flush_d    = {flush_q[SYNC_STAGES-1:0], 1'b1};
    armed_d    = armed_q | (flush_q[SYNC_STAGES] & cs_s);
    load       = 1'b0;
`ifdef SPI_SLAVE_UNDERRUN_EN
    underrun_d = 1'b0;
`endif

    if (tx_byte_valid_i && !buf_full_q) begin
      buf_d      = tx_byte_i;
      buf_full_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall && armed_q) begin
          state_d    = ST_SHIFT;
          load       = 1'b1;
          bit_cnt_d  = 4'd0;
          reload_d   = 1'b0;
          rx_shift_d = 8'h00;
        end
      end
      default: begin
        if (cs_rise) begin
          state_d    = ST_IDLE;
          rx_shift_d = 8'h00;
          bit_cnt_d  = 4'd0;
          reload_d   = 1'b0;
        end else begin
          if (sck_rise) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_s};
            if (bit_cnt_q == 4'(SPI_BITS - 1)) begin
              rx_byte_d  = {rx_shift_q[6:0], mosi_s};
              rx_valid_d = 1'b1;
              reload_d   = 1'b1;
              bit_cnt_d  = 4'd0;
            end else begin
              bit_cnt_d  = bit_cnt_q + 4'd1;
            end
          end
          if (sck_fall) begin
            if (reload_q) begin
              load     = 1'b1;
              reload_d = 1'b0;
            end else begin
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
          end
        end
      end
    endcase

    // A same-cycle write only happens when the buffer was empty, so the load
    // still takes IDLE_BYTE and the written byte waits for the next one.
    if (load) begin
      if (buf_full_q) begin
        tx_shift_d = buf_q;
        buf_full_d = 1'b0;
      end else begin
        tx_shift_d = IDLE_BYTE;
`ifdef SPI_SLAVE_UNDERRUN_EN
        underrun_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_shift_q <= 8'h00;
      rx_shift_q <= 8'h00;
      bit_cnt_q  <= 4'd0;
      reload_q   <= 1'b0;
      rx_byte_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      buf_q      <= 8'h00;
      buf_full_q <= 1'b0;
      armed_q    <= 1'b0;
      flush_q    <= '0;
`ifdef SPI_SLAVE_UNDERRUN_EN
      underrun_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      bit_cnt_q  <= bit_cnt_d;
      reload_q   <= reload_d;
      rx_byte_q  <= rx_byte_d;
      rx_valid_q <= rx_valid_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      armed_q    <= armed_d;
      flush_q    <= flush_d;
`ifdef SPI_SLAVE_UNDERRUN_EN
      underrun_q <= underrun_d;
`endif
    end
  end

  assign miso_o          = (state_q == ST_SHIFT) ? tx_shift_q[7] : 1'b0;
  assign ready_o         = ~buf_full_q;
  assign rx_byte_o       = rx_byte_q;
  assign rx_byte_valid_o = rx_valid_q;
  assign busy_o          = armed_q & ~cs_s;
`ifdef SPI_SLAVE_UNDERRUN_EN
  assign tx_underrun_o   = underrun_q;
`endif

  logic sck_s_unused;
  assign sck_s_unused = sck_s;

endmodule : spi_slave

`default_nettype wire

// File: tb/tb_spi_slave.sv
/*------------------------------------------------------------------------------
 * Module   : tb_spi_slave
 * Purpose  : Directed self-checking bench for spi_slave (100 MHz clk, 12.5 MHz SCK).
 * Revision : 1.0 - initial release
 *----------------------------------------------------------------------------*/
`default_nettype none

module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_valid = 1'b0;
  logic       ready;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       busy;
`ifdef SPI_SLAVE_UNDERRUN_EN
  logic       tx_underrun;
  int         underrun_cnt = 0;
`endif

  int         checks_cnt = 0;
  int         errors_cnt = 0;
  logic [7:0] rx_q[$];
  logic [7:0] m_rx;

  always #5 clk = ~clk;

  spi_slave dut (
    .clk             (clk),
    .rst             (rst),
    .sck_i           (sck),
    .cs_n_i          (cs_n),
    .mosi_i          (mosi),
    .miso_o          (miso),
    .tx_byte_i       (tx_byte),
    .tx_byte_valid_i (tx_valid),
    .ready_o         (ready),
    .rx_byte_o       (rx_byte),
    .rx_byte_valid_o (rx_valid),
    .busy_o          (busy)
`ifdef SPI_SLAVE_UNDERRUN_EN
    ,
    .tx_underrun_o   (tx_underrun)
`endif
  );

  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_byte);
`ifdef SPI_SLAVE_UNDERRUN_EN
    if (tx_underrun) underrun_cnt++;
`endif
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rxq_at(input int k);
    if (rx_q.size() > k) return {24'h0, rx_q[k]};
    return 32'hDEAD;
  endfunction

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    half();
  endtask

  task automatic cs_high();
    half();
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      half();
      sck   = 1'b1;
      rx[i] = miso;
      half();
      sck   = 1'b0;
    end
  endtask

  task automatic buf_write(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("buf_write_ready_timeout", 32'd0, 32'd1);
    tx_byte  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_miso",     {31'h0, miso},     32'd0);
    chk("rst_ready",    {31'h0, ready},    32'd1);
    chk("rst_rx_byte",  {24'h0, rx_byte},  32'h00);
    chk("rst_rx_valid", {31'h0, rx_valid}, 32'd0);
    chk("rst_busy",     {31'h0, busy},     32'd0);
    repeat (8) @(negedge clk);

    // Single byte: master A5, slave 3C
    rx_q.delete();
    buf_write(8'h3C);
    cs_low();
    chk("t1_busy", {31'h0, busy}, 32'd1);
    xfer(8'hA5, 8, m_rx);
    cs_high();
    chk("t1_miso",   {24'h0, m_rx}, 32'h3C);
    chk("t1_pulses", rx_q.size(),   32'd1);
    chk("t1_rx",     rxq_at(0),     32'hA5);

    // Three bytes in one select, buffer refilled after each consume
    rx_q.delete();
    buf_write(8'h10);
    cs_low();
    buf_write(8'h20);
    xfer(8'h01, 8, m_rx);
    chk("t2_miso0", {24'h0, m_rx}, 32'h10);
    buf_write(8'h30);
    xfer(8'h02, 8, m_rx);
    chk("t2_miso1", {24'h0, m_rx}, 32'h20);
    xfer(8'h03, 8, m_rx);
    chk("t2_miso2", {24'h0, m_rx}, 32'h30);
    cs_high();
    chk("t2_pulses", rx_q.size(), 32'd3);
    chk("t2_rx0", rxq_at(0), 32'h01);
    chk("t2_rx1", rxq_at(1), 32'h02);
    chk("t2_rx2", rxq_at(2), 32'h03);

    // Empty buffer at byte start sends the idle byte
    rx_q.delete();
`ifdef SPI_SLAVE_UNDERRUN_EN
    underrun_cnt = 0;
`endif
    chk("t3_ready", {31'h0, ready}, 32'd1);
    cs_low();
    buf_write(8'h77);
    xfer(8'hE7, 8, m_rx);
    cs_high();
    chk("t3_miso", {24'h0, m_rx}, 32'hFF);
    chk("t3_rx",   rxq_at(0),     32'hE7);
`ifdef SPI_SLAVE_UNDERRUN_EN
    chk("t3_underrun", underrun_cnt, 32'd1);
`endif

    // Partial byte discarded, then a full 5A
    rx_q.delete();
    cs_low();
    xfer(8'hC0, 2, m_rx);
    mosi = 1'b1;
    half();
    sck = 1'b1;
    half();
    cs_n = 1'b1;
    half();
    sck = 1'b0;
    repeat (8) @(negedge clk);
    chk("t4_no_pulse", rx_q.size(),     32'd0);
    chk("t4_rx_held",  {24'h0, rx_byte}, 32'hE7);
    cs_low();
    xfer(8'h5A, 8, m_rx);
    cs_high();
    chk("t4_pulses", rx_q.size(), 32'd1);
    chk("t4_rx",     rxq_at(0),   32'h5A);

    // Write held while buffer full is taken right after the consume
    rx_q.delete();
    buf_write(8'h11);
    tx_byte  = 8'h22;
    tx_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("t5_ready_full", {31'h0, ready}, 32'd0);
    cs_low();
    tx_valid = 1'b0;
    chk("t5_ready_refilled", {31'h0, ready}, 32'd0);
    xfer(8'hAA, 8, m_rx);
    chk("t5_miso0", {24'h0, m_rx}, 32'h11);
    xfer(8'h55, 8, m_rx);
    chk("t5_miso1", {24'h0, m_rx}, 32'h22);
    cs_high();
    chk("t5_rx1", rxq_at(1), 32'h55);

    // Reset mid-byte with cs low
    rx_q.delete();
    buf_write(8'h99);
    cs_low();
    xfer(8'hF0, 4, m_rx);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_miso",     {31'h0, miso},     32'd0);
    chk("t6_rst_ready",    {31'h0, ready},    32'd1);
    chk("t6_rst_rx_byte",  {24'h0, rx_byte},  32'h00);
    chk("t6_rst_rx_valid", {31'h0, rx_valid}, 32'd0);
    chk("t6_rst_busy",     {31'h0, busy},     32'd0);
    rst = 1'b0;
    xfer(8'hFF, 8, m_rx);
    xfer(8'hFF, 8, m_rx);
    chk("t6_ignored",    rx_q.size(),      32'd0);
    chk("t6_busy_low",   {31'h0, busy},    32'd0);
    chk("t6_miso_quiet", {24'h0, m_rx},    32'h00);
    cs_high();
    cs_low();
    xfer(8'hC3, 8, m_rx);
    cs_high();
    chk("t6_pulses", rx_q.size(), 32'd1);
    chk("t6_rx",     rxq_at(0),   32'hC3);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule : tb_spi_slave

`default_nettype wire
